// File: rtl/csr_counter_unit.sv
// csr_counter_unit: Zicsr read/modify/write access to the cycle, instret and
// NUM_HPM event counters, mcountinhibit and mscratch. The old value is read
// combinationally; all updates are registered.
// Optional feature macro: CSR_HPM_EN builds the hpm/mhpm event counters and
// their mcountinhibit bits. Without it the HPM addresses read 0 and
// writes to them are discarded.
module csr_counter_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_HPM    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      csr_valid,
  input  logic [11:0]                               csr_addr,
  input  logic [2:0]                                csr_funct3,
  input  logic [DATA_WIDTH-1:0]                     csr_src,
  input  logic                                      csr_src_nz,
  input  logic                                      stall,
  input  logic                                      retire,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0]  hpm_event,
  output logic [DATA_WIDTH-1:0]                     csr_rdata,
  output logic                                      csr_illegal
);

  localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef CSR_HPM_EN
  localparam logic [63:0] HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
`else
  localparam logic [63:0] HPM_BITS = 64'd0;
`endif
  // Only CY (bit 0), IR (bit 2) and implemented HPM bits are writable.
  localparam logic [31:0] INH_MASK = HPM_BITS[31:0] | 32'h0000_0005;

  // Replace one 32-bit half of a counter, holding the other half.
  function automatic logic [CNT_WIDTH-1:0] merge_half(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 hi,
    input logic [31:0]          val
  );
    logic [63:0] merged;
    merged = '0;
    merged[CNT_WIDTH-1:0] = cur;
    if (hi) begin
      merged[63:32] = val;
    end else begin
      merged[31:0] = val;
    end
    return merged[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [31:0]          inhibit_q, inhibit_d;
  logic [31:0]          mscratch_q, mscratch_d;

`ifdef CSR_HPM_EN
  logic [HPM_N-1:0][CNT_WIDTH-1:0] hpm_val;
`endif

  int                   cnt_idx;
  logic                 hi_sel;
  logic                 is_cnt_view;
  logic                 addr_mapped;
  logic [CNT_WIDTH-1:0] cnt_sel;
  logic [63:0]          cnt_ext;
  logic [31:0]          rdata_raw;
  logic                 write_intent;
  logic                 commit;
  logic                 wr_cnt;
  logic [31:0]          wdata;

  // Address decode and the pre-write read mux.
  always_comb begin
    cnt_idx     = {27'd0, csr_addr[4:0]};
    hi_sel      = csr_addr[7];
    is_cnt_view = ((csr_addr[11:8] == 4'hC) || (csr_addr[11:8] == 4'hB)) &&
                  (csr_addr[6:5] == 2'b00);
    addr_mapped = 1'b0;
    cnt_sel     = '0;
    rdata_raw   = '0;
    cnt_ext     = '0;
    if (is_cnt_view) begin
      if (cnt_idx == 0) begin
        addr_mapped = 1'b1;
        cnt_sel     = cycle_q;
      end else if (cnt_idx == 2) begin
        addr_mapped = 1'b1;
        cnt_sel     = instret_q;
      end else if ((cnt_idx >= 3) && (cnt_idx < 3 + NUM_HPM)) begin
        // HPM addresses stay legal even when the counters are not built.
        addr_mapped = 1'b1;
`ifdef CSR_HPM_EN
        for (int i = 0; i < NUM_HPM; i++) begin
          if (cnt_idx == 3 + i) begin
            cnt_sel = hpm_val[i];
          end
        end
`endif
      end
      cnt_ext[CNT_WIDTH-1:0] = cnt_sel;
      rdata_raw = hi_sel ? cnt_ext[63:32] : cnt_ext[31:0];
    end else if (csr_addr == 12'h320) begin
      addr_mapped = 1'b1;
      rdata_raw   = inhibit_q;
    end else if (csr_addr == 12'h340) begin
      addr_mapped = 1'b1;
      rdata_raw   = mscratch_q;
    end
  end

  // Legality, visible read data, commit qualification and write-back value.
  always_comb begin
    case (csr_funct3)
      3'b001, 3'b101:                 write_intent = 1'b1;
      3'b010, 3'b011, 3'b110, 3'b111: write_intent = csr_src_nz;
      default:                        write_intent = 1'b0;
    endcase
    csr_illegal = csr_valid & (~addr_mapped | (write_intent & (csr_addr[11:10] == 2'b11)));
    csr_rdata   = (csr_valid & ~csr_illegal) ? rdata_raw : '0;
    commit      = csr_valid & write_intent & ~stall & ~csr_illegal;
    case (csr_funct3)
      3'b010, 3'b110: wdata = rdata_raw | csr_src;
      3'b011, 3'b111: wdata = rdata_raw & ~csr_src;
      default:        wdata = csr_src;
    endcase
    // Read-only views never commit, so a committed counter write is machine view.
    wr_cnt = commit & is_cnt_view;
  end

  // Cycle and instret next values; a committed write beats the increment.
  always_comb begin
    cycle_d = cycle_q;
    if (wr_cnt && (cnt_idx == 0)) begin
      cycle_d = merge_half(cycle_q, hi_sel, wdata);
    end else if (!inhibit_q[0]) begin
      cycle_d = cycle_q + CNT_ONE;
    end
    instret_d = instret_q;
    if (wr_cnt && (cnt_idx == 2)) begin
      instret_d = merge_half(instret_q, hi_sel, wdata);
    end else if (retire && !inhibit_q[2]) begin
      instret_d = instret_q + CNT_ONE;
    end
  end

  // mcountinhibit and mscratch next values.
  always_comb begin
    inhibit_d  = inhibit_q;
    mscratch_d = mscratch_q;
    if (commit && (csr_addr == 12'h320)) begin
      inhibit_d = wdata & INH_MASK;
    end
    if (commit && (csr_addr == 12'h340)) begin
      mscratch_d = wdata;
    end
  end

  // Core state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q    <= '0;
      instret_q  <= '0;
      inhibit_q  <= '0;
      mscratch_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      inhibit_q  <= inhibit_d;
      mscratch_q <= mscratch_d;
    end
  end

`ifdef CSR_HPM_EN
  for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Event counter next value; a committed write beats the event.
    always_comb begin
      cnt_d = cnt_q;
      if (wr_cnt && (cnt_idx == 3 + gi)) begin
        cnt_d = merge_half(cnt_q, hi_sel, wdata);
      end else if (hpm_event[gi] && !inhibit_q[3 + gi]) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Event counter register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign hpm_val[gi] = cnt_q;
  end
`else
  logic unused_hpm_event;
  assign unused_hpm_event = ^hpm_event;
`endif

endmodule

// File: tb/tb_csr_counter_unit.sv
// tb_csr_counter_unit: directed scenarios followed by random CSR traffic,
// checked against an arithmetic reference model of the CSR file.
module tb_csr_counter_unit;

  localparam int CNT_WIDTH = 64;
  localparam int NUM_HPM   = 4;
  localparam int NUM_CNT   = 2 + NUM_HPM;
  localparam longint unsigned CMASK =
    (CNT_WIDTH == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_WIDTH) - 64'd1);
`ifdef CSR_HPM_EN
  localparam bit HPM_ON = 1'b1;
`else
  localparam bit HPM_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               csr_valid;
  logic [11:0]        csr_addr;
  logic [2:0]         csr_funct3;
  logic [31:0]        csr_src;
  logic               csr_src_nz;
  logic               stall;
  logic               retire;
  logic [NUM_HPM-1:0] hpm_event;
  logic [31:0]        csr_rdata;
  logic               csr_illegal;

  always #5 clk = ~clk;

  csr_counter_unit #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_HPM   (NUM_HPM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_valid  (csr_valid),
    .csr_addr   (csr_addr),
    .csr_funct3 (csr_funct3),
    .csr_src    (csr_src),
    .csr_src_nz (csr_src_nz),
    .stall      (stall),
    .retire     (retire),
    .hpm_event  (hpm_event),
    .csr_rdata  (csr_rdata),
    .csr_illegal(csr_illegal)
  );

  // Reference model state: counter n is cycle (0), instret (1), hpm n-2.
  longint unsigned m_cnt [NUM_CNT];
  logic [31:0]     m_inh;
  logic [31:0]     m_scratch;
  int              n_checks = 0;
  int              n_fail   = 0;

  function automatic int cnt_num(input int n);
    return (n == 0) ? 0 : ((n == 1) ? 2 : n + 1);
  endfunction

  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = 32'h5;
    if (HPM_ON) begin
      for (int i = 0; i < NUM_HPM; i++) m[3 + i] = 1'b1;
    end
    return m;
  endfunction

  function automatic void lookup(input logic [11:0] a, output bit mapped, output logic [31:0] val);
    mapped = 1'b0;
    val    = 32'h0;
    if (a == 12'h320) begin
      mapped = 1'b1;
      val    = m_inh;
    end else if (a == 12'h340) begin
      mapped = 1'b1;
      val    = m_scratch;
    end else begin
      for (int n = 0; n < NUM_CNT; n++) begin
        for (int v = 0; v < 2; v++) begin
          for (int h = 0; h < 2; h++) begin
            if (int'(a) == ((v == 0) ? 32'hC00 : 32'hB00) + h * 32'h80 + cnt_num(n)) begin
              mapped = 1'b1;
              val    = (h == 1) ? 32'(m_cnt[n] >> 32) : 32'(m_cnt[n]);
            end
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NUM_CNT; n++) m_cnt[n] = 64'd0;
    m_inh     = 32'h0;
    m_scratch = 32'h0;
  endtask

  // One clock: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step(input string tag, input logic v, input logic [11:0] a,
                      input logic [2:0] f3, input logic [31:0] src, input logic nz,
                      input logic st, input logic ret, input logic [NUM_HPM-1:0] ev,
                      output logic [31:0] obs_rd, output logic obs_ill);
    bit              mapped, wi, legal, commit;
    logic [31:0]     val, exp_rd, wval;
    logic            exp_ill;
    longint unsigned old [NUM_CNT];
    logic [31:0]     old_inh;
    @(negedge clk);
    csr_valid  = v;
    csr_addr   = a;
    csr_funct3 = f3;
    csr_src    = src;
    csr_src_nz = nz;
    stall      = st;
    retire     = ret;
    hpm_event  = ev;
    #1;
    lookup(a, mapped, val);
    wi      = (f3 == 3'b001) || (f3 == 3'b101) ||
              (nz && (f3 == 3'b010 || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111));
    legal   = mapped && !(wi && (a >= 12'hC00));
    exp_ill = v && !legal;
    exp_rd  = (v && legal) ? val : 32'h0;
    obs_rd  = csr_rdata;
    obs_ill = csr_illegal;
    $display("[%0t] %s v=%0b addr=%h f3=%0d src=%h nz=%0b stall=%0b ret=%0b ev=%b rdata=%h ill=%0b",
             $time, tag, v, a, f3, src, nz, st, ret, ev, obs_rd, obs_ill);
    check({tag, "_rdata"}, obs_rd, exp_rd);
    check({tag, "_illegal"}, {31'd0, obs_ill}, {31'd0, exp_ill});
    commit = v && wi && !st && legal;
    if (f3 == 3'b010 || f3 == 3'b110)      wval = val | src;
    else if (f3 == 3'b011 || f3 == 3'b111) wval = val & ~src;
    else                                   wval = src;
    @(posedge clk);
    old     = m_cnt;
    old_inh = m_inh;
    m_cnt[0] = (old[0] + (old_inh[0] ? 64'd0 : 64'd1)) & CMASK;
    m_cnt[1] = (old[1] + ((ret && !old_inh[2]) ? 64'd1 : 64'd0)) & CMASK;
    for (int i = 0; i < NUM_HPM; i++) begin
      if (HPM_ON && ev[i] && !old_inh[3 + i]) m_cnt[2 + i] = (old[2 + i] + 64'd1) & CMASK;
    end
    if (commit) begin
      if (a == 12'h320) m_inh = wval & inh_mask();
      else if (a == 12'h340) m_scratch = wval;
      else begin
        for (int n = 0; n < NUM_CNT; n++) begin
          if (n < 2 || HPM_ON) begin
            if (int'(a) == 32'hB00 + cnt_num(n))
              m_cnt[n] = (old[n] & 64'hFFFF_FFFF_0000_0000) | {32'd0, wval};
            else if (int'(a) == 32'hB80 + cnt_num(n))
              m_cnt[n] = ((old[n] & 64'h0000_0000_FFFF_FFFF) | ({32'd0, wval} << 32)) & CMASK;
          end
        end
      end
    end
  endtask

  task automatic csr(input string tag, input logic [11:0] a, input logic [2:0] f3,
                     input logic [31:0] src, input logic nz, input logic st,
                     output logic [31:0] obs_rd, output logic obs_ill);
    step(tag, 1'b1, a, f3, src, nz, st, 1'b0, '0, obs_rd, obs_ill);
  endtask

  task automatic idle(input int n, input logic ret, input logic [NUM_HPM-1:0] ev);
    logic [31:0] rd;
    logic        il;
    for (int i = 0; i < n; i++) step("idle", 1'b0, 12'h000, 3'b000, 32'h0, 1'b0, 1'b0, ret, ev, rd, il);
  endtask

  // Reset for two edges, optionally with a committing mscratch write held alongside.
  task automatic do_reset(input bit with_write);
    @(negedge clk);
    rst        = 1'b1;
    csr_valid  = with_write;
    csr_addr   = 12'h340;
    csr_funct3 = 3'b001;
    csr_src    = 32'hDEAD_BEEF;
    csr_src_nz = 1'b1;
    stall      = 1'b0;
    retire     = 1'b1;
    hpm_event  = '1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    csr_valid = 1'b0;
    retire    = 1'b0;
    hpm_event = '0;
    model_reset();
  endtask

  logic [11:0] addr_pool [22] = '{
    12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03, 12'hC84, 12'hC06, 12'hB00,
    12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB86, 12'hB04, 12'h320, 12'h340,
    12'hC01, 12'hC07, 12'hB07, 12'h321, 12'h7C0, 12'hF11
  };
  logic [2:0] f3_pool [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    logic [31:0] rd;
    logic        il;
    rst = 1'b0; csr_valid = 1'b0; csr_addr = 12'h0; csr_funct3 = 3'b0; csr_src = 32'h0;
    csr_src_nz = 1'b0; stall = 1'b0; retire = 1'b0; hpm_event = '0;
    model_reset();

    // Reset state, then 10 idle cycles.
    do_reset(1'b0);
    idle(10, 1'b0, '0);
    csr("rd_c00", 12'hC00, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("cycle_after_10", rd, 32'd10);
    csr("rd_c80", 12'hC80, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("cycleh_after_10", rd, 32'd0);
    csr("rd_c02", 12'hC02, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("instret_after_10", rd, 32'd0);

    // Preload mcycle to 0xFFFF_FFFF and watch the low half carry.
    csr("wr_b00", 12'hB00, 3'b001, 32'hFFFF_FFFF, 1'b1, 1'b0, rd, il);
    csr("wr_b80", 12'hB80, 3'b001, 32'h0, 1'b0, 1'b0, rd, il);
    idle(1, 1'b0, '0);
    csr("rd_c00", 12'hC00, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("cycle_lo_wrap", rd, 32'd0);
    csr("rd_c80", 12'hC80, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("cycle_hi_carry", rd, 32'd1);

    // Inhibit cycle and instret, then release.
    csr("wr_320", 12'h320, 3'b001, 32'h5, 1'b1, 1'b0, rd, il);
    idle(4, 1'b1, '0);
    csr("rd_c00", 12'hC00, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    csr("rd_c02", 12'hC02, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("instret_frozen", rd, 32'd0);
    csr("clr_320", 12'h320, 3'b101, 32'h0, 1'b0, 1'b0, rd, il);
    idle(3, 1'b1, '0);
    csr("rd_c02", 12'hC02, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("instret_resumed", rd, 32'd3);
    csr("rd_c00", 12'hC00, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);

    // Read-only view: set with nz is illegal, set without nz is a plain read.
    csr("rs_c00_nz", 12'hC00, 3'b010, 32'h1, 1'b1, 1'b0, rd, il);
    check("ro_write_illegal", {31'd0, il}, 32'd1);
    csr("rs_c00_z", 12'hC00, 3'b010, 32'h1, 1'b0, 1'b0, rd, il);
    check("ro_read_legal", {31'd0, il}, 32'd0);

    // mscratch clear held off by stall.
    csr("wr_340", 12'h340, 3'b001, 32'hA5A5_0000, 1'b1, 1'b0, rd, il);
    csr("rc_340_st", 12'h340, 3'b011, 32'hFFFF_0000, 1'b1, 1'b1, rd, il);
    csr("rc_340_st", 12'h340, 3'b011, 32'hFFFF_0000, 1'b1, 1'b1, rd, il);
    check("scratch_stalled", rd, 32'hA5A5_0000);
    csr("rc_340", 12'h340, 3'b011, 32'hFFFF_0000, 1'b1, 1'b0, rd, il);
    csr("rd_340", 12'h340, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("scratch_cleared", rd, 32'h0);

    // Reset wins over a concurrent write.
    csr("wr_340", 12'h340, 3'b001, 32'h0000_1234, 1'b1, 1'b0, rd, il);
    do_reset(1'b1);
    csr("rd_340", 12'h340, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("reset_beats_write", rd, 32'h0);

    // Event counter 1.
    idle(7, 1'b0, 4'b0010);
    csr("rd_b04", 12'hB04, 3'b010, 32'h0, 1'b0, 1'b0, rd, il);
    check("hpm1_count", rd, HPM_ON ? 32'd7 : 32'd0);
    check("hpm1_legal", {31'd0, il}, 32'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step("rand",
           ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           addr_pool[$urandom_range(0, 21)],
           f3_pool[$urandom_range(0, 5)],
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           NUM_HPM'($urandom),
           rd, il);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
